mono_hit_assembler: RTL and testbench



---
 rtl/mono_hit_assembler.sv | 174 +++++++++++++++++
 tb/tb_mono_hit_assembler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mono_hit_assembler.sv
// Reassembles four-word MONO hit frames from a FWFT word FIFO into one parallel hit record.
// Optional token-counter continuity check: define MONO_HIT_ASM_TOKEN_CHECK_EN.
//
// state | meaning
// HUNT  | discard words until a W1 (tag 01, correct identifier)
// GET1  | frame boundary, expecting W1 of the next frame
// GET2  | W1 held, expecting W2 (tag 10)
// GET3  | W2 held, expecting W3 (tag 11)
// GET4  | W3 held, expecting W4 (tag 00); pop waits while output is stalled
module mono_hit_assembler #(
  parameter logic [1:0] IDENTIFIER = 2'b00
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        IN_EMPTY,
  input  logic [31:0] IN_DATA,
  output logic        IN_READ,
  output logic        HIT_VALID,
  input  logic        HIT_READY,
  output logic [5:0]  HIT_COL,
  output logic [7:0]  HIT_ROW,
  output logic [7:0]  HIT_LE,
  output logic [7:0]  HIT_TE,
  output logic        HIT_NOISE,
  output logic [51:0] HIT_TS,
  output logic [27:0] HIT_TOKEN_CNT,
  output logic [31:0] HIT_CNT,
  output logic [15:0] FRAME_ERR_CNT,
  output logic [15:0] TOKEN_GAP_CNT
);

  typedef enum logic [2:0] {HUNT, GET1, GET2, GET3, GET4} state_t;

  state_t      state, state_nxt;
  logic [11:0] ts_lo, ts_mid;
  logic [27:0] ts_hi;
  logic [7:0]  row_q, le_q, te_q;
  logic [5:0]  col_q;
  logic        noise_q;

  logic        stall, pop, id_ok;
  logic [1:0]  tag, exp_tag;
  logic        cap_w1, cap_w2, cap_w3, load, frame_err;

  assign stall   = (state == GET4) && HIT_VALID && !HIT_READY;
  assign pop     = !IN_EMPTY && !stall;
  assign IN_READ = pop;
  assign tag     = IN_DATA[29:28];
  assign id_ok   = (IN_DATA[31:30] == IDENTIFIER);

  always_comb begin
    exp_tag = 2'b01;
    case (state)
      GET2:    exp_tag = 2'b10;
      GET3:    exp_tag = 2'b11;
      GET4:    exp_tag = 2'b00;
      default: exp_tag = 2'b01;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cap_w1    = 1'b0;
    cap_w2    = 1'b0;
    cap_w3    = 1'b0;
    load      = 1'b0;
    frame_err = 1'b0;
    if (pop) begin
      if (state == HUNT) begin
        if (id_ok && tag == 2'b01) begin
          cap_w1    = 1'b1;
          state_nxt = GET2;
        end
      end else if (!id_ok) begin
        frame_err = 1'b1;
        state_nxt = HUNT;
      end else if (tag != exp_tag) begin
        // A misplaced W1 restarts the frame instead of being thrown away
        frame_err = 1'b1;
        if (tag == 2'b01) begin
          cap_w1    = 1'b1;
          state_nxt = GET2;
        end else begin
          state_nxt = HUNT;
        end
      end else begin
        case (state)
          GET1:    begin cap_w1 = 1'b1; state_nxt = GET2; end
          GET2:    begin cap_w2 = 1'b1; state_nxt = GET3; end
          GET3:    begin cap_w3 = 1'b1; state_nxt = GET4; end
          GET4:    begin load   = 1'b1; state_nxt = GET1; end
          default: state_nxt = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state         <= HUNT;
      ts_lo         <= '0;
      ts_mid        <= '0;
      ts_hi         <= '0;
      row_q         <= '0;
      le_q          <= '0;
      te_q          <= '0;
      col_q         <= '0;
      noise_q       <= 1'b0;
      HIT_VALID     <= 1'b0;
      HIT_COL       <= '0;
      HIT_ROW       <= '0;
      HIT_LE        <= '0;
      HIT_TE        <= '0;
      HIT_NOISE     <= 1'b0;
      HIT_TS        <= '0;
      HIT_TOKEN_CNT <= '0;
      HIT_CNT       <= '0;
      FRAME_ERR_CNT <= '0;
    end else begin
      state <= state_nxt;
      if (cap_w1) begin
        ts_lo   <= IN_DATA[27:16];
        row_q   <= IN_DATA[15:8];
        noise_q <= IN_DATA[6];
        col_q   <= IN_DATA[5:0];
      end
      if (cap_w2) begin
        ts_mid <= IN_DATA[27:16];
        le_q   <= IN_DATA[15:8];
        te_q   <= IN_DATA[7:0];
      end
      if (cap_w3)
        ts_hi <= IN_DATA[27:0];
      if (frame_err && FRAME_ERR_CNT != 16'hFFFF)
        FRAME_ERR_CNT <= FRAME_ERR_CNT + 16'd1;
      // Load wins over a same-cycle transfer so the valid bit stays high
      if (load) begin
        HIT_VALID     <= 1'b1;
        HIT_COL       <= col_q;
        HIT_ROW       <= row_q;
        HIT_LE        <= le_q;
        HIT_TE        <= te_q;
        HIT_NOISE     <= noise_q;
        HIT_TS        <= {ts_hi, ts_mid, ts_lo};
        HIT_TOKEN_CNT <= IN_DATA[27:0];
        HIT_CNT       <= HIT_CNT + 32'd1;
      end else if (HIT_VALID && HIT_READY) begin
        HIT_VALID <= 1'b0;
      end
    end
  end

`ifdef MONO_HIT_ASM_TOKEN_CHECK_EN
  logic        seen_load;
  logic [27:0] tok_next;

  assign tok_next = HIT_TOKEN_CNT + 28'd1;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      seen_load     <= 1'b0;
      TOKEN_GAP_CNT <= '0;
    end else if (load) begin
      seen_load <= 1'b1;
      if (seen_load && IN_DATA[27:0] != HIT_TOKEN_CNT && IN_DATA[27:0] != tok_next
          && TOKEN_GAP_CNT != 16'hFFFF)
        TOKEN_GAP_CNT <= TOKEN_GAP_CNT + 16'd1;
    end
  end
`else
  assign TOKEN_GAP_CNT = '0;
`endif

endmodule

// File: tb/tb_mono_hit_assembler.sv
// Scoreboard bench for mono_hit_assembler: a word-queue driver feeds the FWFT input,
// expected records are queued at issue time and a monitor checks each output transfer.
module tb_mono_hit_assembler;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST;
  logic        IN_EMPTY;
  logic [31:0] IN_DATA;
  logic        IN_READ;
  logic        HIT_VALID;
  logic        HIT_READY;
  logic [5:0]  HIT_COL;
  logic [7:0]  HIT_ROW;
  logic [7:0]  HIT_LE;
  logic [7:0]  HIT_TE;
  logic        HIT_NOISE;
  logic [51:0] HIT_TS;
  logic [27:0] HIT_TOKEN_CNT;
  logic [31:0] HIT_CNT;
  logic [15:0] FRAME_ERR_CNT;
  logic [15:0] TOKEN_GAP_CNT;

  mono_hit_assembler #(.IDENTIFIER(2'b00)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
    .IN_EMPTY(IN_EMPTY), .IN_DATA(IN_DATA), .IN_READ(IN_READ),
    .HIT_VALID(HIT_VALID), .HIT_READY(HIT_READY),
    .HIT_COL(HIT_COL), .HIT_ROW(HIT_ROW), .HIT_LE(HIT_LE), .HIT_TE(HIT_TE),
    .HIT_NOISE(HIT_NOISE), .HIT_TS(HIT_TS), .HIT_TOKEN_CNT(HIT_TOKEN_CNT),
    .HIT_CNT(HIT_CNT), .FRAME_ERR_CNT(FRAME_ERR_CNT), .TOKEN_GAP_CNT(TOKEN_GAP_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  typedef struct packed {
    logic [5:0]  col;
    logic [7:0]  row;
    logic        noise;
    logic [7:0]  le;
    logic [7:0]  te;
    logic [51:0] ts;
    logic [27:0] tok;
  } rec_t;

  rec_t        sb_q[$];
  logic [31:0] src_q[$];
  int          xfer_cyc[$];
  logic        rdy = 1'b1;
  logic        pop_now;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          read_low = 0;

  always @(posedge BUS_CLK) cyc <= cyc + 1;

  // Driver: present head of src_q at negedge, pop it if the DUT reads at the next posedge
  always begin
    @(negedge BUS_CLK);
    HIT_READY = rdy;
    if (src_q.size() > 0) begin
      IN_EMPTY = 1'b0;
      IN_DATA  = src_q[0];
    end else begin
      IN_EMPTY = 1'b1;
      IN_DATA  = 32'h0;
    end
    #1;
    pop_now = !IN_EMPTY && IN_READ;
    if (!IN_EMPTY && !IN_READ) read_low++;
    @(posedge BUS_CLK);
    if (pop_now && src_q.size() > 0) void'(src_q.pop_front());
  end

  // Monitor: every transfer is compared against the scoreboard head
  always begin
    rec_t got, exp;
    @(negedge BUS_CLK);
    #3;
    if (!BUS_RST && HIT_VALID && HIT_READY) begin
      got = '{col: HIT_COL, row: HIT_ROW, noise: HIT_NOISE, le: HIT_LE, te: HIT_TE,
              ts: HIT_TS, tok: HIT_TOKEN_CNT};
      xfer_cyc.push_back(cyc);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record got=%h required=none", got);
      end else begin
        exp = sb_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL record got=%h required=%h", got, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge BUS_CLK);
    #2;
  endtask

  function automatic rec_t mk(input logic [5:0] col, input logic [7:0] row, input logic noise,
                              input logic [7:0] le, input logic [7:0] te,
                              input logic [51:0] ts, input logic [27:0] tok);
    mk = '{col: col, row: row, noise: noise, le: le, te: te, ts: ts, tok: tok};
  endfunction

  function automatic void push_w12(input rec_t r);
    src_q.push_back({2'b00, 2'b01, r.ts[11:0], r.row, 1'b0, r.noise, r.col});
    src_q.push_back({2'b00, 2'b10, r.ts[23:12], r.le, r.te});
  endfunction

  function automatic void push_frame(input rec_t r, input bit expect_rec);
    push_w12(r);
    src_q.push_back({2'b00, 2'b11, r.ts[51:24]});
    src_q.push_back({2'b00, 2'b00, r.tok});
    if (expect_rec) sb_q.push_back(r);
  endfunction

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((src_q.size() != 0 || sb_q.size() != 0) && n < limit) begin
      step(1);
      n++;
    end
    step(2);
    chk({name, "_pending"}, 64'(sb_q.size() + src_q.size()), 64'd0);
  endtask

  initial begin
    rec_t ra, rb, rc, rd;
    int   exp_gap;
    int   bad_gap;
    BUS_RST = 1'b1;
    step(3);
    BUS_RST = 1'b0;
    step(1);

    chk("rst_valid",  64'(HIT_VALID), 64'd0);
    chk("rst_hitcnt", 64'(HIT_CNT), 64'd0);
    chk("rst_errcnt", 64'(FRAME_ERR_CNT), 64'd0);
    chk("rst_gapcnt", 64'(TOKEN_GAP_CNT), 64'd0);
    chk("rst_ts",     64'(HIT_TS), 64'd0);
    chk("rst_read_empty", 64'(IN_READ), 64'd0);

    // Hand-built frame: COL=5 ROW=3A NOISE=1 LE=55 TE=66 TS=0000001123ABC TOK=7
    src_q.push_back(32'h1ABC_3A45);
    src_q.push_back(32'h2123_5566);
    src_q.push_back(32'h3000_0001);
    src_q.push_back(32'h0000_0007);
    sb_q.push_back(mk(6'd5, 8'h3A, 1'b1, 8'h55, 8'h66, 52'h0000001123ABC, 28'd7));
    @(negedge BUS_CLK);
    #2;
    chk("hunt_read", 64'(IN_READ), 64'd1);
    drain("single", 40);
    chk("single_hitcnt", 64'(HIT_CNT), 64'd1);
    chk("single_errcnt", 64'(FRAME_ERR_CNT), 64'd0);

    // Eight back-to-back frames
    read_low = 0;
    xfer_cyc.delete();
    for (int i = 0; i < 8; i++)
      push_frame(mk(6'(i + 1), 8'(8'h10 * i), 1'(i), 8'(i * 3), 8'(255 - i),
                    52'h1_2345_6789_0000 + 52'(i), 28'(100 + i)), 1'b1);
    drain("b2b", 100);
    chk("b2b_read_low", 64'(read_low), 64'd0);
    chk("b2b_hitcnt", 64'(HIT_CNT), 64'd9);
    bad_gap = 0;
    for (int i = 1; i < xfer_cyc.size(); i++)
      if (xfer_cyc[i] - xfer_cyc[i-1] != 4) bad_gap++;
    chk("b2b_xfers", 64'(xfer_cyc.size()), 64'd8);
    chk("b2b_spacing", 64'(bad_gap), 64'd0);

    // Output stall with two more frames queued behind the first record
    rdy = 1'b0;
    for (int i = 0; i < 3; i++)
      push_frame(mk(6'h20 + 6'(i), 8'hA0, 1'b0, 8'h11, 8'h22, 52'hF_0000_0000_0000 + 52'(i),
                    28'(20 + i)), 1'b1);
    step(14);
    chk("stall_valid", 64'(HIT_VALID), 64'd1);
    chk("stall_read",  64'(IN_READ), 64'd0);
    chk("stall_left",  64'(src_q.size()), 64'd5);
    chk("stall_hold",  64'(HIT_TOKEN_CNT), 64'd20);
    rdy = 1'b1;
    drain("stall", 60);
    chk("stall_hitcnt", 64'(HIT_CNT), 64'd12);

    // W1 W2 then a fresh W1: partial frame dropped, new frame kept
    ra = mk(6'd1, 8'd2, 1'b0, 8'd3, 8'd4, 52'h111, 28'd50);
    rb = mk(6'd9, 8'hC3, 1'b1, 8'h7E, 8'h81, 52'hA_BCDE_F012_3456, 28'd51);
    push_w12(ra);
    push_frame(rb, 1'b1);
    drain("restart", 40);
    chk("restart_errcnt", 64'(FRAME_ERR_CNT), 64'd1);
    chk("restart_hitcnt", 64'(HIT_CNT), 64'd13);

    // Wrong identifier between W2 and W3: back to HUNT, W3/W4 silently dropped
    rc = mk(6'd7, 8'd8, 1'b0, 8'd9, 8'd10, 52'h222, 28'd60);
    rd = mk(6'h3F, 8'hFF, 1'b1, 8'h01, 8'hFE, 52'h0_0000_0FFF_F000, 28'd61);
    push_w12(rc);
    src_q.push_back(32'h5000_0000);
    src_q.push_back({2'b00, 2'b11, rc.ts[51:24]});
    src_q.push_back({2'b00, 2'b00, rc.tok});
    push_frame(rd, 1'b1);
    drain("badid", 40);
    chk("badid_errcnt", 64'(FRAME_ERR_CNT), 64'd2);
    chk("badid_hitcnt", 64'(HIT_CNT), 64'd14);

    // Reset with a pending record and a half-received frame
    rdy = 1'b0;
    push_frame(mk(6'd1, 8'd1, 1'b1, 8'd1, 8'd1, 52'h1, 28'd1), 1'b0);
    push_w12(mk(6'd2, 8'd2, 1'b0, 8'd2, 8'd2, 52'h2, 28'd2));
    drain("pre_rst", 30);
    chk("pre_rst_valid", 64'(HIT_VALID), 64'd1);
    BUS_RST = 1'b1;
    step(1);
    chk("mid_rst_valid",  64'(HIT_VALID), 64'd0);
    chk("mid_rst_hitcnt", 64'(HIT_CNT), 64'd0);
    chk("mid_rst_errcnt", 64'(FRAME_ERR_CNT), 64'd0);
    chk("mid_rst_tok",    64'(HIT_TOKEN_CNT), 64'd0);
    chk("mid_rst_col",    64'(HIT_COL), 64'd0);
    BUS_RST = 1'b0;
    rdy = 1'b1;
    step(1);

    // Token sequence after reset: 4,5,5,6,9 -> only 6->9 is a discontinuity
    push_frame(mk(6'd12, 8'h34, 1'b0, 8'h56, 8'h78, 52'h9_8765_4321_0FED, 28'd4), 1'b1);
    push_frame(mk(6'd13, 8'h01, 1'b1, 8'h02, 8'h03, 52'h5, 28'd5), 1'b1);
    push_frame(mk(6'd14, 8'h01, 1'b0, 8'h02, 8'h03, 52'h6, 28'd5), 1'b1);
    push_frame(mk(6'd15, 8'h01, 1'b1, 8'h02, 8'h03, 52'h7, 28'd6), 1'b1);
    push_frame(mk(6'd16, 8'h01, 1'b0, 8'h02, 8'h03, 52'h8, 28'd9), 1'b1);
    drain("token", 80);
`ifdef MONO_HIT_ASM_TOKEN_CHECK_EN
    exp_gap = 1;
`else
    exp_gap = 0;
`endif
    chk("token_gapcnt", 64'(TOKEN_GAP_CNT), 64'(exp_gap));
    chk("token_hitcnt", 64'(HIT_CNT), 64'd5);
    chk("token_errcnt", 64'(FRAME_ERR_CNT), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
